// File: rtl/mult_datapath.sv
// mult_datapath: X/A/B registers, 9-bit add/subtract and arithmetic shift for the signed shift-add multiplier.
// Optional MULT_INPUT_SYNC_EN: two-flop synchronizer on Din before it is used as the multiplicand.
module mult_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] Din,
    input  logic             ClrA_LdB,
    input  logic             Clr_AX,
    input  logic             Add_En,
    input  logic             Fn,
    input  logic             Shift_En,
    output logic             M,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             Cnt_Done
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             x;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   s_ext;
    logic [WIDTH:0]   sum;

`ifdef MULT_INPUT_SYNC_EN
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= Din;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = Din;
`endif

    // Sign-extend both operands to 9 bits so the top bit of the result becomes the new X.
    assign a_ext = {a[WIDTH-1], a};
    assign s_ext = {s[WIDTH-1], s};
    assign sum   = Fn ? a_ext - s_ext : a_ext + s_ext;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x   <= 1'b0;
            a   <= '0;
            b   <= '0;
            cnt <= '0;
        end else if (ClrA_LdB) begin
            x   <= 1'b0;
            a   <= '0;
            b   <= s;
            cnt <= '0;
        end else if (Clr_AX) begin
            x   <= 1'b0;
            a   <= '0;
            cnt <= '0;
        end else if (Add_En) begin
            if (b[0]) begin
                x <= sum[WIDTH];
                a <= sum[WIDTH-1:0];
            end
        end else if (Shift_En) begin
            a <= {x, a[WIDTH-1:1]};
            b <= {a[0], b[WIDTH-1:1]};
            if (cnt != CW'(WIDTH))
                cnt <= cnt + CW'(1);
        end
    end

    assign M        = b[0];
    assign Aval     = a;
    assign Bval     = b;
    assign X        = x;
    assign Cnt_Done = (cnt == CW'(WIDTH));
endmodule
